mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one 32-bit asynchronous SRAM between the IF stage (instruction fetch) and the MEM stage (LW/LB/SW/SB).
- Sequences each SRAM access as a multi-cycle read or write and raises a pipeline-wide stall until every pending request completes.
- Sits between the pipeline stages and the board SRAM pins.
- MEM has strict priority over IF.

Parameters:
- WAIT_CYCLES, 1, extra SRAM access cycles beyond the first; legal range 0..7.
- SRAM_AW, 20, SRAM word-address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  IF fetch request; held stable until if_ready.
- if_addr  in  32  IF byte address; word-aligned.
- if_rdata  out  32  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_rd  in  1  MEM load request; held until mem_ready.
- mem_wr  in  1  MEM store request; held until mem_ready.
- mem_byte  in  1  1 = LB/SB, 0 = LW/SW.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data; byte ops use bits 7:0.
- mem_rdata  out  32  load data; LB result sign-extended; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- stall  out  1  freeze PC and pipeline registers.
- sram_addr  out  SRAM_AW  word address = latched addr[SRAM_AW+1:2].
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- sram_be_n  out  4  byte enables, active-low; lane0 = bits 7:0 (little-endian).
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset values: if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_addr=0, sram_wdata=0, state=IDLE.
- Reset effect is immediate (asynchronous), including mid-access: the access is aborted and no ready pulse is issued.
- FSM state IDLE:
  - If mem_rd|mem_wr, grant MEM; else if if_req, grant IF.
  - On grant, latch address, op, byte flag and wdata; load counter=WAIT_CYCLES; go to ACCESS.
  - With no request, stay in IDLE.
- FSM state ACCESS:
  - ce_n=0; be_n driven.
  - Read: oe_n=0. Write: we_n=0.
  - When counter==0: read captures sram_rdata into the granted port's rdata register; go to DONE. Otherwise decrement the counter.
- FSM state DONE:
  - ready pulse=1 for the granted port only.
  - ce_n=0; oe_n=1; we_n=1; address and wdata held (write hold time).
  - Next state is always IDLE. Re-granting from DONE is forbidden because the requester still holds req that cycle.
- Latency: grant cycle N, ACCESS cycles N+1..N+1+WAIT_CYCLES, ready at N+2+WAIT_CYCLES. Minimum gap between consecutive grants is WAIT_CYCLES+3 cycles.
- Word ops: be_n=4'b0000; addr[1:0] ignored.
- Byte ops, with k=addr[1:0]:
  - be_n has only bit k low.
  - SB: sram_wdata = wdata[7:0] replicated to all four lanes.
  - LB: mem_rdata = sign-extend(sram_rdata[8k+7:8k]).
- mem_rd and mem_wr both high: treated as a write.
- stall = ((mem_rd|mem_wr) & ~mem_ready) | (if_req & ~if_ready). It is combinational and drops in the ready cycle so the pipeline advances on that edge.
- IF starvation is allowed. Any MEM request blocks IF, but the pipeline is frozen under stall, so MEM cannot re-request.
- rdata registers hold their last value outside ready.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACCESS, DONE};
  - grant encoding {GNT_IF, GNT_MEM};
  - WAIT_CYCLES width constant (3 bits);
  - load/store opcodes LW=6'b100011, LB=6'b100000, SW=6'b101011, SB=6'b101000, used by the MEM-stage request decode.
- One sub-module, mem_byte_lane: combinational be_n generation, SB data replication and LB lane select with sign extension.

Test Plan:
- IF fetch at 0x0000_0010, WAIT_CYCLES=1, sram_rdata=0x8C01_0004 -> sram_addr=0x00004; oe_n=0 cycles 1-2; if_ready=1 cycle 3 with if_rdata=0x8C01_0004; stall=1 cycles 0-2.
- if_req and mem_rd both rise in cycle 0 (WAIT_CYCLES=1) -> mem_ready cycle 3; IF granted cycle 4; if_ready cycle 7; stall=1 cycles 0-6.
- SB addr 0x0000_0103, wdata=0x0000_00A5 -> be_n=4'b0111; sram_wdata=0xA5A5_A5A5; we_n=0 only in ACCESS; ce_n=0 through DONE; mem_ready one cycle.
- LB addr 0x0000_0202, sram_rdata=0x0080_0000 -> mem_rdata=0xFFFF_FF80. LW same address, sram_rdata=0x1234_5678 -> mem_rdata=0x1234_5678, be_n=4'b0000.
- rst_n low mid-ACCESS of a write -> we_n, ce_n, oe_n=1 and be_n=4'hF in the same cycle; no mem_ready. After release, the held request is re-granted from IDLE and completes normally.
- WAIT_CYCLES=0 -> single ACCESS cycle; ready at cycle 2; back-to-back IF fetches granted at cycles 0 and 3.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the IF/MEM SRAM arbiter:
//   - arbiter FSM state encoding
//   - grant owner encoding
//   - width of the wait-state counter
//   - MIPS load/store opcodes and a small decode helper for the MEM stage
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  // Wait-state counter width; holds WAIT_CYCLES in the range 0..7.
  localparam int WAIT_W = 3;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SB = 6'b101000;

  typedef struct packed {
    logic rd;
    logic wr;
    logic byte_op;
  } mem_op_t;

  // Turns a MEM-stage opcode into the request strobes this arbiter expects.
  function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
    mem_op_t op;
    op = '0;
    case (opcode)
      OP_LW: op.rd = 1'b1;
      OP_LB: begin op.rd = 1'b1; op.byte_op = 1'b1; end
      OP_SW: op.wr = 1'b1;
      OP_SB: begin op.wr = 1'b1; op.byte_op = 1'b1; end
      default: op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// ---------------------------------------------------------------------------
// mem_byte_lane
// Combinational byte-lane steering for the 32-bit little-endian SRAM.
//   byte_i   : 1 = byte access (LB/SB), 0 = word access
//   lane_i   : byte offset addr[1:0]; only used for byte accesses
//   wdata_i  : store data (byte stores use bits 7:0)
//   rdata_i  : raw SRAM read word
//   be_n_o   : active-low byte enables, lane0 = bits 7:0
//   wdata_o  : SRAM write data (byte stores replicated to every lane)
//   rdata_o  : load result (byte loads sign-extended from the selected lane)
// ---------------------------------------------------------------------------
module mem_byte_lane
  import mem_arbiter_pkg::*;
(
  input  logic        byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_n_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0] lane_byte;

  always_comb begin
    be_n_o    = 4'b0000;
    wdata_o   = wdata_i;
    rdata_o   = rdata_i;
    lane_byte = rdata_i[7:0];
    case (lane_i)
      2'd0: lane_byte = rdata_i[7:0];
      2'd1: lane_byte = rdata_i[15:8];
      2'd2: lane_byte = rdata_i[23:16];
      default: lane_byte = rdata_i[31:24];
    endcase
    if (byte_i) begin
      be_n_o  = ~(4'b0001 << lane_i);
      // Replicating the byte lets the SRAM pick it up on whichever lane is enabled.
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = {{24{lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one 32-bit asynchronous SRAM between instruction fetch (IF) and the
// MEM stage. MEM has strict priority. Each access is IDLE -> ACCESS for
// WAIT_CYCLES+1 cycles -> DONE (one-cycle ready pulse) -> IDLE.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_rdata/if_ready          fetched word and its completion pulse
//   mem_rd/mem_wr/mem_byte     load/store request (held until mem_ready)
//   mem_addr/mem_wdata         load/store address and store data
//   mem_rdata/mem_ready        load result and its completion pulse
//   stall                      freeze the pipeline while anything is pending
//   sram_*                     board SRAM pins (controls active-low)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ready,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic               mem_byte,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic [3:0]         sram_be_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [3:0]        lane_be_n;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  // Address bits above the SRAM word range are not decoded.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:SRAM_AW+2];

  mem_byte_lane u_lane (
    .byte_i  (byte_q),
    .lane_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (sram_rdata),
    .be_n_o  (lane_be_n),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          gnt_d   = GNT_MEM;
          // A simultaneous rd+wr is resolved as a store.
          wr_d    = mem_wr;
          byte_d  = mem_byte;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end else if (if_req) begin
          gnt_d   = GNT_IF;
          wr_d    = 1'b0;
          byte_d  = 1'b0;
          addr_d  = if_addr;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (gnt_q == GNT_MEM) mem_rdata_d = lane_rdata;
            else                  if_rdata_d  = sram_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Always pass through IDLE: the finishing requester still holds its
      // request during DONE and must not be granted twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pin controls decode straight from registered state, so an
  // asynchronous reset releases the bus in the same cycle.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 4'hF;
    case (state_q)
      ACCESS: begin
        sram_ce_n = 1'b0;
        sram_be_n = lane_be_n;
        sram_oe_n = wr_q;
        sram_we_n = ~wr_q;
      end
      DONE: begin
        // Chip stays selected with address/data held for write hold time.
        sram_ce_n = 1'b0;
        sram_be_n = lane_be_n;
      end
      default: ;
    endcase
  end

  assign sram_addr  = addr_q[SRAM_AW+1:2];
  assign sram_wdata = lane_wdata;
  assign if_ready   = (state_q == DONE) && (gnt_q == GNT_IF);
  assign mem_ready  = (state_q == DONE) && (gnt_q == GNT_MEM);
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  // Drops in the ready cycle so the pipeline advances on that edge.
  assign stall      = ((mem_rd | mem_wr) & ~mem_ready) | (if_req & ~if_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, mem_byte = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, stall, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;

  mem_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // Second instance with zero wait states, used only for fetch streaming.
  logic        if_req0 = 1'b0, mem_rd0 = 1'b0, mem_wr0 = 1'b0, mem_byte0 = 1'b0;
  logic [31:0] if_addr0 = '0, mem_addr0 = '0, mem_wdata0 = '0;
  logic [31:0] if_rdata0, mem_rdata0, sram_wdata0, sram_rdata0;
  logic        if_ready0, mem_ready0, stall0, sram_ce_n0, sram_oe_n0, sram_we_n0;
  logic [19:0] sram_addr0;
  logic [3:0]  sram_be_n0;

  mem_arbiter #(.WAIT_CYCLES(0), .SRAM_AW(20)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
    .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_byte(mem_byte0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .stall(stall0),
    .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0),
    .sram_be_n(sram_be_n0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0)
  );

  assign sram_rdata0 = (!sram_ce_n0 && !sram_oe_n0) ? {12'hC0D, sram_addr0} : 32'hDEAD_BEEF;

  // SRAM model for the main instance: 256 words, byte-lane writes.
  logic [31:0] smem [256];
  logic [31:0] ref_mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_a = '0;
  logic [31:0] bd_d = '0;

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? smem[sram_addr[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bd_we) smem[bd_a] <= bd_d;
    else if (!sram_ce_n && !sram_we_n)
      for (int l = 0; l < 4; l++)
        if (!sram_be_n[l]) smem[sram_addr[7:0]][8*l +: 8] <= sram_wdata[8*l +: 8];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d; ref_mem[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // mk: 0 none, 1 LW, 2 LB, 3 SW, 4 SB, 5 rd+wr word, 6 rd+wr byte
  task automatic txn(input bit do_if, input logic [31:0] ia, input int mk,
                     input logic [31:0] ma, input logic [31:0] wd, input string nm);
    bit has_mem, is_wr, is_byte, aw;
    int k, s_if, r_mem, r_if, last, ph;
    logic [7:0]  mw, iw, b;
    logic [3:0]  m_be, a_be;
    logic [19:0] aa;
    logic [31:0] exp_m, exp_i, exp_wd, w;
    has_mem = (mk != 0);
    is_wr   = (mk >= 3);
    is_byte = (mk == 2) || (mk == 4) || (mk == 6);
    k  = int'(ma[1:0]);
    mw = ma[9:2];
    iw = ia[9:2];
    m_be  = is_byte ? ~(4'b0001 << k) : 4'b0000;
    exp_m = '0;
    exp_wd = is_byte ? {4{wd[7:0]}} : wd;
    if (has_mem && !is_wr) begin
      w = ref_mem[mw];
      b = w[8*k +: 8];
      exp_m = is_byte ? {{24{b[7]}}, b} : w;
    end
    if (has_mem && is_wr) begin
      if (is_byte) ref_mem[mw][8*k +: 8] = wd[7:0];
      else         ref_mem[mw] = wd;
    end
    exp_i = ref_mem[iw];
    s_if  = has_mem ? W + 3 : 0;
    r_mem = has_mem ? W + 2 : -10;
    r_if  = do_if ? s_if + W + 2 : -10;
    last  = (r_mem > r_if) ? r_mem : r_if;
    for (int c = 0; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if_req = do_if; if_addr = ia;
        mem_rd = (mk == 1) || (mk == 2) || (mk >= 5);
        mem_wr = is_wr; mem_byte = is_byte; mem_addr = ma; mem_wdata = wd;
      end else begin
        if (c - 1 == r_mem) begin mem_rd = 1'b0; mem_wr = 1'b0; end
        if (c - 1 == r_if) if_req = 1'b0;
      end
      #1;
      ph = 0; aw = 1'b0; aa = '0; a_be = 4'hF;
      if (has_mem && c >= 1 && c <= r_mem) begin
        ph = (c == r_mem) ? 2 : 1; aw = is_wr; aa = ma[21:2]; a_be = m_be;
      end else if (do_if && c >= s_if + 1 && c <= r_if) begin
        ph = (c == r_if) ? 2 : 1; aw = 1'b0; aa = ia[21:2]; a_be = 4'b0000;
      end
      chk($sformatf("%s mem_ready c%0d", nm, c), {31'd0, mem_ready}, {31'd0, c == r_mem});
      chk($sformatf("%s if_ready c%0d", nm, c), {31'd0, if_ready}, {31'd0, c == r_if});
      chk($sformatf("%s stall c%0d", nm, c), {31'd0, stall}, {31'd0, c < last});
      chk($sformatf("%s ce_n c%0d", nm, c), {31'd0, sram_ce_n}, {31'd0, ph == 0});
      chk($sformatf("%s oe_n c%0d", nm, c), {31'd0, sram_oe_n}, {31'd0, !(ph == 1 && !aw)});
      chk($sformatf("%s we_n c%0d", nm, c), {31'd0, sram_we_n}, {31'd0, !(ph == 1 && aw)});
      chk($sformatf("%s be_n c%0d", nm, c), {28'd0, sram_be_n}, {28'd0, a_be});
      if (ph != 0) chk($sformatf("%s sram_addr c%0d", nm, c), {12'd0, sram_addr}, {12'd0, aa});
      if (ph != 0 && aw) chk($sformatf("%s sram_wdata c%0d", nm, c), sram_wdata, exp_wd);
      if ((c == r_mem || c == last + 1) && has_mem && !is_wr)
        chk($sformatf("%s mem_rdata c%0d", nm, c), mem_rdata, exp_m);
      if ((c == r_if || c == last + 1) && do_if)
        chk($sformatf("%s if_rdata c%0d", nm, c), if_rdata, exp_i);
    end
  endtask

  initial begin
    // Reset state, preload memory while the arbiters are held in reset.
    for (int i = 0; i < 256; i++) bd_write(8'(i), $urandom);
    @(negedge clk); #1;
    chk("rst if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("rst oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst be_n", {28'd0, sram_be_n}, 32'hF);
    chk("rst sram_addr", {12'd0, sram_addr}, 32'd0);
    chk("rst sram_wdata", sram_wdata, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases.
    bd_write(8'h04, 32'h8C01_0004);
    txn(1'b1, 32'h0000_0010, 0, 32'h0, 32'h0, "fetch");
    bd_write(8'h20, 32'hCAFE_0123);
    txn(1'b1, 32'h0000_0010, 1, 32'h0000_0080, 32'h0, "if_mem");
    txn(1'b0, 32'h0, 4, 32'h0000_0103, 32'h0000_00A5, "sb");
    txn(1'b0, 32'h0, 1, 32'h0000_0100, 32'h0, "sb_readback");
    bd_write(8'h80, 32'h0080_0000);
    txn(1'b0, 32'h0, 2, 32'h0000_0202, 32'h0, "lb");
    bd_write(8'h80, 32'h1234_5678);
    txn(1'b0, 32'h0, 1, 32'h0000_0202, 32'h0, "lw");
    txn(1'b0, 32'h0, 5, 32'h0000_0044, 32'h5566_7788, "rdwr");
    txn(1'b0, 32'h0, 1, 32'h0000_0044, 32'h0, "rdwr_readback");

    // Reset in the middle of a store's ACCESS phase.
    @(negedge clk);
    mem_wr = 1'b1; mem_rd = 1'b0; mem_byte = 1'b0;
    mem_addr = 32'h0000_0040; mem_wdata = 32'h1122_3344;
    #1 chk("abort stall c0", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("abort we_n access", {31'd0, sram_we_n}, 32'd0);
    rst_n = 1'b0; #1;
    chk("abort we_n", {31'd0, sram_we_n}, 32'd1);
    chk("abort ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("abort oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("abort be_n", {28'd0, sram_be_n}, 32'hF);
    chk("abort mem_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk); #1;
    chk("abort mem_ready held", {31'd0, mem_ready}, 32'd0);
    chk("abort ce_n held", {31'd0, sram_ce_n}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(1'b0, 32'h0, 3, 32'h0000_0040, 32'h1122_3344, "abort_resume");
    txn(1'b0, 32'h0, 1, 32'h0000_0040, 32'h0, "abort_readback");

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      int mk;
      bit di;
      mk = int'($urandom_range(0, 6));
      di = (mk == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      txn(di, 32'($urandom_range(0, 255)) << 2, mk, 32'($urandom_range(0, 1023)),
          $urandom, $sformatf("rnd%0d", n));
    end

    // Zero wait states: back-to-back fetches granted at cycles 0 and 3.
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin if_req0 = 1'b1; if_addr0 = 32'h0000_0020; end
      if (c == 3) if_addr0 = 32'h0000_0024;
      if (c == 6) if_req0 = 1'b0;
      #1;
      chk($sformatf("w0 if_ready c%0d", c), {31'd0, if_ready0}, {31'd0, c == 2 || c == 5});
      chk($sformatf("w0 oe_n c%0d", c), {31'd0, sram_oe_n0}, {31'd0, !(c == 1 || c == 4)});
      chk($sformatf("w0 stall c%0d", c), {31'd0, stall0}, {31'd0, c != 2 && c != 5 && c < 6});
      if (c == 2) chk("w0 if_rdata first", if_rdata0, 32'hC0D0_0008);
      if (c == 5) chk("w0 if_rdata second", if_rdata0, 32'hC0D0_0009);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
